// File: rtl/tantra_spike_decoder_if.sv
// Decision output bundle of the spike decoder: valid/ready handshake plus result payload.
// The decoder drives through the master modport; the actuator/host side uses slave.
interface tantra_spike_decoder_if #(
  parameter int NUM_CH    = 8,
  parameter int CNT_WIDTH = 8
);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                        out_valid;
  logic                        out_ready;
  logic [IDX_W-1:0]            out_class;
  logic [CNT_WIDTH-1:0]        out_count;
  logic                        out_confident;
  logic                        out_saturated;
  logic [NUM_CH*CNT_WIDTH-1:0] out_counts;
  logic [7:0]                  drop_count;

  modport master (
    output out_valid, out_class, out_count, out_confident,
           out_saturated, out_counts, drop_count,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_class, out_count, out_confident,
           out_saturated, out_counts, drop_count,
    output out_ready
  );
endinterface

// File: rtl/tantra_spike_decoder.sv
// Windowed per-channel spike counter with snapshot and sequential argmax.
// Live counting keeps running while a finished window is scanned or held.
module tantra_spike_decoder #(
  parameter int NUM_CH     = 8,
  parameter int WINDOW_LEN = 64,
  parameter int CNT_WIDTH  = 8,
  parameter int MIN_SPIKES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [NUM_CH-1:0] spikes_in,
  tantra_spike_decoder_if.master dec
);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WIN_W = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] MIN_CNT  = CNT_WIDTH'(MIN_SPIKES);
  localparam logic [WIN_W-1:0]     WIN_LAST = WIN_W'(WINDOW_LEN - 1);
  localparam logic [WIN_W-1:0]     WIN_ONE  = WIN_W'(1);
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(NUM_CH - 1);
  localparam logic [IDX_W-1:0]     IDX_ONE  = IDX_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_HOLD} state_t;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic inc);
    return (inc && (v != CNT_MAX)) ? v + CNT_ONE : v;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v != 8'hFF) ? v + 8'd1 : v;
  endfunction

  state_t               state, state_nxt;
  logic [WIN_W-1:0]     win_cnt_p0;
  logic [CNT_WIDTH-1:0] live_p0  [NUM_CH];
  logic [CNT_WIDTH-1:0] live_nxt [NUM_CH];
  logic                 sat_p0, sat_nxt;
  logic [CNT_WIDTH-1:0] snap_p1  [NUM_CH];
  logic                 snap_sat_p1;
  logic [IDX_W-1:0]     scan_idx_p2;
  logic [IDX_W-1:0]     best_idx_p2, nb_idx;
  logic [CNT_WIDTH-1:0] best_cnt_p2, nb_cnt, cand_cnt;
  logic                 conf_p2;
  logic [7:0]           drop_cnt;
  logic [NUM_CH*CNT_WIDTH-1:0] counts_flat;
  logic                 win_end, accept;

  // Stage 0: live window accumulation
  always_comb begin
    sat_nxt = sat_p0;
    for (int c = 0; c < NUM_CH; c++) begin
      live_nxt[c] = sat_inc(live_p0[c], spikes_in[c]);
      if (spikes_in[c] && (live_p0[c] == CNT_MAX)) sat_nxt = 1'b1;
    end
  end

  assign win_end = enable && (win_cnt_p0 == WIN_LAST);
  assign accept  = win_end && ((state == S_IDLE) || ((state == S_HOLD) && dec.out_ready));

  always_ff @(posedge clk) begin
    if (rst || !enable || win_end) begin
      win_cnt_p0 <= '0;
      sat_p0     <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) live_p0[c] <= '0;
    end else begin
      win_cnt_p0 <= win_cnt_p0 + WIN_ONE;
      sat_p0     <= sat_nxt;
      for (int c = 0; c < NUM_CH; c++) live_p0[c] <= live_nxt[c];
    end
  end

  // Stage 1: snapshot on acceptance, drop accounting otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_sat_p1 <= 1'b0;
      drop_cnt    <= '0;
      for (int c = 0; c < NUM_CH; c++) snap_p1[c] <= '0;
    end else if (accept) begin
      snap_sat_p1 <= sat_nxt;
      for (int c = 0; c < NUM_CH; c++) snap_p1[c] <= live_nxt[c];
    end else if (win_end) begin
      drop_cnt <= sat_inc8(drop_cnt);
    end
  end

  // Stage 2: sequential argmax, one channel per cycle
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_SCAN;
      S_SCAN: if (scan_idx_p2 == IDX_LAST) state_nxt = S_HOLD;
      S_HOLD: if (dec.out_ready) state_nxt = accept ? S_SCAN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cand_cnt = snap_p1[scan_idx_p2];
    nb_cnt   = best_cnt_p2;
    nb_idx   = best_idx_p2;
    if (scan_idx_p2 == '0) begin
      nb_cnt = cand_cnt;
      nb_idx = '0;
    end else if (cand_cnt > best_cnt_p2) begin
      nb_cnt = cand_cnt;
      nb_idx = scan_idx_p2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_idx_p2 <= '0;
      best_cnt_p2 <= '0;
      best_idx_p2 <= '0;
      conf_p2     <= 1'b0;
    end else begin
      if (accept)                scan_idx_p2 <= '0;
      else if (state == S_SCAN)  scan_idx_p2 <= scan_idx_p2 + IDX_ONE;
      if (state == S_SCAN) begin
        best_cnt_p2 <= nb_cnt;
        best_idx_p2 <= nb_idx;
        if (scan_idx_p2 == IDX_LAST) conf_p2 <= (nb_cnt >= MIN_CNT);
      end
    end
  end

  always_comb begin
    counts_flat = '0;
    for (int c = 0; c < NUM_CH; c++) counts_flat[c*CNT_WIDTH +: CNT_WIDTH] = snap_p1[c];
  end

  assign dec.out_valid     = (state == S_HOLD);
  assign dec.out_class     = best_idx_p2;
  assign dec.out_count     = best_cnt_p2;
  assign dec.out_confident = conf_p2;
  assign dec.out_saturated = snap_sat_p1;
  assign dec.out_counts    = counts_flat;
  assign dec.drop_count    = drop_cnt;
endmodule

// File: tb/tb_tantra_spike_decoder.sv
// Scoreboard bench: stimulus pushes hand-computed decisions, monitors pop on each handshake.
// Instance a uses 8-bit counts over 16-cycle windows; instance b uses 4-bit counts over 32.
module tb_tantra_spike_decoder;
  logic       clk = 1'b0;
  logic       rst;
  logic       en_a, en_b;
  logic [7:0] spikes_a, spikes_b;
  int         checks = 0;
  int         errors = 0;

  typedef struct {
    logic [63:0] cls;
    logic [63:0] cnt;
    logic [63:0] conf;
    logic [63:0] sat;
    logic [63:0] counts;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  tantra_spike_decoder_if #(.NUM_CH(8), .CNT_WIDTH(8)) ifa ();
  tantra_spike_decoder_if #(.NUM_CH(8), .CNT_WIDTH(4)) ifb ();

  tantra_spike_decoder #(.NUM_CH(8), .WINDOW_LEN(16), .CNT_WIDTH(8), .MIN_SPIKES(1)) dut_a (
    .clk(clk), .rst(rst), .enable(en_a), .spikes_in(spikes_a), .dec(ifa)
  );
  tantra_spike_decoder #(.NUM_CH(8), .WINDOW_LEN(32), .CNT_WIDTH(4), .MIN_SPIKES(1)) dut_b (
    .clk(clk), .rst(rst), .enable(en_b), .spikes_in(spikes_b), .dec(ifb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] one_ch(input int ch, input int val, input int w);
    logic [63:0] r;
    r = 64'(val);
    return r << (ch * w);
  endfunction

  function automatic exp_t mk(input int cls, input int cnt, input int conf, input int sat,
                              input logic [63:0] counts);
    exp_t e;
    e.cls = 64'(cls); e.cnt = 64'(cnt); e.conf = 64'(conf); e.sat = 64'(sat);
    e.counts = counts;
    return e;
  endfunction

  task automatic step(input logic [7:0] s, input logic en);
    spikes_a = s;
    en_a     = en;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && ifa.out_valid && ifa.out_ready) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_output", 64'(1), 64'(0));
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_class",     64'(ifa.out_class),     e.cls);
        chk("a_count",     64'(ifa.out_count),     e.cnt);
        chk("a_confident", 64'(ifa.out_confident), e.conf);
        chk("a_saturated", 64'(ifa.out_saturated), e.sat);
        chk("a_counts",    64'(ifa.out_counts),    e.counts);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ifb.out_valid && ifb.out_ready) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_output", 64'(1), 64'(0));
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_class",     64'(ifb.out_class),     e.cls);
        chk("b_count",     64'(ifb.out_count),     e.cnt);
        chk("b_confident", 64'(ifb.out_confident), e.conf);
        chk("b_saturated", 64'(ifb.out_saturated), e.sat);
        chk("b_counts",    64'(ifb.out_counts),    e.counts);
      end
    end
  end

  initial begin
    rst = 1'b1; en_a = 1'b0; en_b = 1'b0; spikes_a = '0; spikes_b = '0;
    ifa.out_ready = 1'b1;
    ifb.out_ready = 1'b1;
    repeat (3) step(8'h00, 1'b0);
    chk("rst_valid",  64'(ifa.out_valid),     64'(0));
    chk("rst_class",  64'(ifa.out_class),     64'(0));
    chk("rst_count",  64'(ifa.out_count),     64'(0));
    chk("rst_conf",   64'(ifa.out_confident), 64'(0));
    chk("rst_counts", 64'(ifa.out_counts),    64'(0));
    chk("rst_drop",   64'(ifa.drop_count),    64'(0));
    rst = 1'b0;
    step(8'h00, 1'b0);

    // one-hot on channel 2, latency to out_valid
    qa.push_back(mk(2, 16, 1, 0, one_ch(2, 16, 8)));
    for (int k = 0; k < 16; k++) step(8'h04, 1'b1);
    repeat (7) step(8'h00, 1'b0);
    chk("onehot_valid_c23", 64'(ifa.out_valid), 64'(0));
    step(8'h00, 1'b0);
    chk("onehot_valid_c24", 64'(ifa.out_valid), 64'(1));
    step(8'h00, 1'b0);
    chk("onehot_valid_c25", 64'(ifa.out_valid), 64'(0));
    repeat (2) step(8'h00, 1'b0);

    // tie between channels 1 and 5 resolves low
    qa.push_back(mk(1, 10, 1, 0, one_ch(1, 10, 8) | one_ch(3, 9, 8) | one_ch(5, 10, 8)));
    for (int k = 0; k < 16; k++) step((k < 9) ? 8'h2A : ((k == 9) ? 8'h22 : 8'h00), 1'b1);
    repeat (12) step(8'h00, 1'b0);

    // silent window
    qa.push_back(mk(0, 0, 0, 0, 64'(0)));
    for (int k = 0; k < 16; k++) step(8'h00, 1'b1);
    repeat (12) step(8'h00, 1'b0);

    // backpressure across three window ends
    ifa.out_ready = 1'b0;
    qa.push_back(mk(0, 16, 1, 0, one_ch(0, 16, 8)));
    for (int k = 0; k < 64; k++) begin
      ifa.out_ready = (k == 50);
      if (k == 48) begin
        chk("bp_held_valid", 64'(ifa.out_valid),  64'(1));
        chk("bp_held_class", 64'(ifa.out_class),  64'(0));
        chk("bp_held_count", 64'(ifa.out_count),  64'(16));
        chk("bp_held_counts", 64'(ifa.out_counts), one_ch(0, 16, 8));
        chk("bp_drops",      64'(ifa.drop_count), 64'(2));
      end
      if (k == 51) qa.push_back(mk(4, 16, 1, 0, one_ch(4, 16, 8)));
      step((k < 16) ? 8'h01 : (k < 32) ? 8'h02 : (k < 48) ? 8'h08 : 8'h10, 1'b1);
    end
    ifa.out_ready = 1'b0;
    repeat (7) step(8'h00, 1'b0);
    chk("bp_next_valid_c71", 64'(ifa.out_valid), 64'(0));
    step(8'h00, 1'b0);
    chk("bp_next_valid_c72", 64'(ifa.out_valid), 64'(1));
    ifa.out_ready = 1'b1;
    repeat (3) step(8'h00, 1'b0);
    chk("bp_drops_final", 64'(ifa.drop_count), 64'(2));

    // enable dropped mid-window discards the partial count
    qa.push_back(mk(6, 16, 1, 0, one_ch(6, 16, 8)));
    for (int k = 0; k < 10; k++) step(8'hFF, 1'b1);
    repeat (3) step(8'h00, 1'b0);
    for (int k = 0; k < 16; k++) step(8'h40, 1'b1);
    repeat (12) step(8'h00, 1'b0);
    chk("en_drops_unchanged", 64'(ifa.drop_count), 64'(2));

    // reset while holding a result
    ifa.out_ready = 1'b0;
    for (int k = 0; k < 16; k++) step(8'h20, 1'b1);
    repeat (8) step(8'h00, 1'b0);
    chk("hold_valid_before_rst", 64'(ifa.out_valid), 64'(1));
    chk("hold_class_before_rst", 64'(ifa.out_class), 64'(5));
    rst = 1'b1;
    step(8'h00, 1'b0);
    chk("hrst_valid",  64'(ifa.out_valid),     64'(0));
    chk("hrst_class",  64'(ifa.out_class),     64'(0));
    chk("hrst_count",  64'(ifa.out_count),     64'(0));
    chk("hrst_conf",   64'(ifa.out_confident), 64'(0));
    chk("hrst_sat",    64'(ifa.out_saturated), 64'(0));
    chk("hrst_counts", 64'(ifa.out_counts),    64'(0));
    chk("hrst_drop",   64'(ifa.drop_count),    64'(0));
    rst = 1'b0;
    ifa.out_ready = 1'b1;
    step(8'h00, 1'b0);

    // saturation on the 4-bit instance
    qb.push_back(mk(7, 15, 1, 1, one_ch(7, 15, 4)));
    spikes_b = 8'h80;
    en_b     = 1'b1;
    repeat (32) step(8'h00, 1'b0);
    en_b     = 1'b0;
    spikes_b = 8'h00;
    repeat (12) step(8'h00, 1'b0);
    chk("b_drops", 64'(ifb.drop_count), 64'(0));

    chk("a_queue_drained", 64'(qa.size()), 64'(0));
    chk("b_queue_drained", 64'(qb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
